// File: rtl/kb_read_arbiter.sv
// kb_read_arbiter: shares the keyboard character buffer between the CPU
// I/O port and the terminal echo unit, and serializes buffer flushes.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   cpu_req/ack/data/empty    CPU read channel (level req, 1-cycle ack)
//   echo_req/ack/data/empty   echo unit read channel (same protocol)
//   clear_req/clear_done      flush request pulse / completion pulse
//   overflow            sticky copy of buf_full, cleared by a flush
//   KB_status, KB_data  buffer non-empty flag and head character
//   buf_full            buffer full flag
//   KB_read_en          one-cycle pop strobe
//   KB_clear            flush strobe, held CLEAR_CYCLES cycles
module kb_read_arbiter #(
    parameter int DATA_W        = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int CLEAR_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_empty,
    input  logic              echo_req,
    output logic              echo_ack,
    output logic [DATA_W-1:0] echo_data,
    output logic              echo_empty,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              overflow,
    input  logic              KB_status,
    input  logic [DATA_W-1:0] KB_data,
    input  logic              buf_full,
    output logic              KB_read_en,
    output logic              KB_clear
);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        SETTLE,
        CLEAR
    } state_t;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_ECHO = 1'b1;

    // Counters are loaded with N-1 so the state lasts exactly N cycles.
    localparam logic [3:0] SET_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] CLR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        clear_pend;
    logic        last_grant;
    logic        any_req;
    logic        pick_echo;
    logic [DATA_W-1:0] head;

    // Round-robin: echo wins alone, or on a tie when the CPU went last.
    always_comb begin
        any_req   = cpu_req | echo_req;
        pick_echo = echo_req & (~cpu_req | (last_grant == GNT_CPU));
        head      = KB_status ? KB_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_pend <= 1'b0;
            last_grant <= GNT_ECHO;
            cpu_ack    <= 1'b0;
            cpu_data   <= '0;
            cpu_empty  <= 1'b0;
            echo_ack   <= 1'b0;
            echo_data  <= '0;
            echo_empty <= 1'b0;
            clear_done <= 1'b0;
            overflow   <= 1'b0;
            KB_read_en <= 1'b0;
            KB_clear   <= 1'b0;
        end else begin
            if (clear_req) begin
                clear_pend <= 1'b1;
            end

            // Completing flush reloads from buf_full so a set wins.
            if (state == CLEAR && cnt == 4'd0) begin
                overflow <= buf_full;
            end else if (buf_full) begin
                overflow <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    // A clear_req arriving now is folded into this flush.
                    if (clear_pend || clear_req) begin
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        KB_clear   <= 1'b1;
                        cnt        <= CLR_LAST;
                        clear_done <= (CLR_LAST == 4'd0);
                    end else if (any_req) begin
                        state      <= RESP;
                        last_grant <= pick_echo;
                        cpu_ack    <= ~pick_echo;
                        echo_ack   <= pick_echo;
                        KB_read_en <= KB_status;
                        cpu_data   <= pick_echo ? '0 : head;
                        echo_data  <= pick_echo ? head : '0;
                        cpu_empty  <= ~pick_echo & ~KB_status;
                        echo_empty <= pick_echo & ~KB_status;
                    end
                end

                RESP: begin
                    cpu_ack    <= 1'b0;
                    echo_ack   <= 1'b0;
                    cpu_data   <= '0;
                    echo_data  <= '0;
                    cpu_empty  <= 1'b0;
                    echo_empty <= 1'b0;
                    KB_read_en <= 1'b0;
                    // KB_read_en still holds the latched hit here.
                    if (KB_read_en) begin
                        state <= SETTLE;
                        cnt   <= SET_LAST;
                    end else begin
                        state <= IDLE;
                    end
                end

                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                CLEAR: begin
                    if (cnt == 4'd0) begin
                        state      <= IDLE;
                        KB_clear   <= 1'b0;
                        clear_done <= 1'b0;
                    end else begin
                        cnt        <= cnt - 4'd1;
                        clear_done <= (cnt == 4'd1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
